byte_mask_mem_initiator: RTL and testbench

- Initiator (master) side of the byte-strobed synchronous memory interface: avalid/aready/awren/astrb/aaddr/adata request channel, rvalid/rready/rdata response channel.
- Converts upstream load/store requests into word-addressed, byte-strobed memory accesses. Requests carry a byte address, a size (byte/half/word) and a signed flag.
- Realigns and extends read data, tracks outstanding accesses in order, and reports misaligned accesses as errors.
- Sits between an LSU/testbench driver and a synch byte-mask SRAM.

---
 rtl/byte_mask_mem_initiator.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_byte_mask_mem_initiator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_mask_mem_initiator.sv
// -----------------------------------------------------------------------------
// byte_mask_mem_initiator
//
// Initiator side of a byte-strobed synchronous memory interface. Upstream
// load/store requests (byte address, size, signed flag) are turned into
// word-addressed, byte-strobed memory accesses. Read beats are realigned and
// sign/zero-extended. Misaligned or reserved-size requests are answered with
// an error response and never reach memory. A small in-order tracking FIFO
// pairs each memory beat with the request that caused it.
//
// Optional feature macro: BMI_WRITE_ACK_EN
//   defined   : every store also produces an upstream response (data 0, err 0)
//   undefined : store beats are consumed silently
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   upstream request handshake
//   req_we                1 = store, 0 = load
//   req_size              0 byte, 1 half, 2 word, 3 reserved
//   req_signed            sign-extend load result
//   req_baddr             byte address (ADDRW+2 bits)
//   req_wdata             right-aligned store data
//   rsp_valid/rsp_ready   upstream response handshake (rsp_* registered)
//   rsp_data, rsp_err     aligned/extended load data, error flag
//   avalid/aready         memory request handshake
//   awren, astrb          memory write enable and byte strobes
//   aaddr, adata          memory word address and lane-replicated store data
//   rvalid/rready, rdata  memory response handshake and read data
// -----------------------------------------------------------------------------
module byte_mask_mem_initiator #(
  parameter int DATAW       = 32,
  parameter int ADDRW       = 7,
  parameter int OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst,
  // upstream request
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [ADDRW+1:0]   req_baddr,
  input  logic [DATAW-1:0]   req_wdata,
  // upstream response
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATAW-1:0]   rsp_data,
  output logic               rsp_err,
  // memory request
  output logic               avalid,
  input  logic               aready,
  output logic               awren,
  output logic [DATAW/8-1:0] astrb,
  output logic [ADDRW-1:0]   aaddr,
  output logic [DATAW-1:0]   adata,
  // memory response
  input  logic               rvalid,
  output logic               rready,
  input  logic [DATAW-1:0]   rdata
);

  localparam int STRBW = DATAW / 8;
  localparam int PTRW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNTW  = $clog2(OUTSTANDING + 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(OUTSTANDING);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(OUTSTANDING - 1);

  typedef enum logic [1:0] {
    KIND_READ  = 2'd0,
    KIND_WRITE = 2'd1,
    KIND_ERR   = 2'd2
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] off;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Tracking FIFO storage and state
  // ---------------------------------------------------------------------------
  entry_t          fifo_mem [OUTSTANDING];
  logic [PTRW-1:0] wr_ptr_reg;
  logic [PTRW-1:0] rd_ptr_reg;
  logic [CNTW-1:0] count_reg;

  logic            fifo_full;
  logic            fifo_empty;
  entry_t          head;

  // Full is derived from registered state only, so req_ready never sees a
  // combinational path from this cycle's pop.
  assign fifo_full  = (count_reg == DEPTH);
  assign fifo_empty = (count_reg == '0);
  assign head       = fifo_mem[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  logic             rsp_valid_reg;
  logic [DATAW-1:0] rsp_data_reg;
  logic             rsp_err_reg;

  logic             rsp_free;
  logic             rsp_load;
  logic [DATAW-1:0] rsp_load_data;
  logic             rsp_load_err;

  // Free when empty or being drained this cycle; load and drain may overlap.
  assign rsp_free = !rsp_valid_reg || rsp_ready;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, zero latency)
  // ---------------------------------------------------------------------------
  logic [1:0] off;
  logic       aligned;
  logic       push;
  entry_t     push_entry;

  assign off = req_baddr[1:0];

  always_comb begin
    aligned = 1'b0;
    astrb   = '0;
    adata   = req_wdata;
    case (req_size)
      2'd0: begin
        aligned = 1'b1;
        astrb   = STRBW'(1) << off;
        adata   = {(DATAW/8){req_wdata[7:0]}};
      end
      2'd1: begin
        aligned = !off[0];
        astrb   = STRBW'(3) << off;
        adata   = {(DATAW/16){req_wdata[15:0]}};
      end
      2'd2: begin
        aligned = (off == 2'd0);
        astrb   = '1;
        adata   = req_wdata;
      end
      default: begin
        // Reserved size: never aligned, never issued to memory.
        aligned = 1'b0;
        astrb   = '0;
        adata   = req_wdata;
      end
    endcase
  end

  // Misaligned requests only need FIFO space; aligned ones also need memory.
  assign avalid    = !rst && req_valid && aligned && !fifo_full;
  assign req_ready = !rst && !fifo_full && (aligned ? aready : 1'b1);
  assign awren     = req_we;
  assign aaddr     = req_baddr[ADDRW+1:2];
  assign push      = req_valid && req_ready;

  always_comb begin
    push_entry.size = req_size;
    push_entry.sgn  = req_signed;
    push_entry.off  = off;
    if (!aligned) begin
      push_entry.kind = KIND_ERR;
    end else if (req_we) begin
      push_entry.kind = KIND_WRITE;
    end else begin
      push_entry.kind = KIND_READ;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data realignment and extension for the head entry
  // ---------------------------------------------------------------------------
  logic [DATAW-1:0] shifted;
  logic [DATAW-1:0] extended;

  always_comb begin
    shifted  = rdata >> {head.off, 3'b000};
    extended = shifted;
    case (head.size)
      2'd0: extended = head.sgn ? {{(DATAW-8){shifted[7]}}, shifted[7:0]}
                                : {{(DATAW-8){1'b0}}, shifted[7:0]};
      2'd1: extended = head.sgn ? {{(DATAW-16){shifted[15]}}, shifted[15:0]}
                                : {{(DATAW-16){1'b0}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Head processing: strictly in order, at most one retirement per cycle
  // ---------------------------------------------------------------------------
  logic pop;

  always_comb begin
    rready        = 1'b0;
    pop           = 1'b0;
    rsp_load      = 1'b0;
    rsp_load_data = '0;
    rsp_load_err  = 1'b0;
    if (!rst && !fifo_empty) begin
      case (head.kind)
        KIND_READ: begin
          rready = rsp_free;
          if (rvalid && rsp_free) begin
            pop           = 1'b1;
            rsp_load      = 1'b1;
            rsp_load_data = extended;
          end
        end
        KIND_WRITE: begin
`ifdef BMI_WRITE_ACK_EN
          // Write ack needs the response register, so back-pressure the beat.
          rready = rsp_free;
          if (rvalid && rsp_free) begin
            pop      = 1'b1;
            rsp_load = 1'b1;
          end
`else
          // Write beat carries nothing upstream; always swallow it.
          rready = 1'b1;
          if (rvalid) begin
            pop = 1'b1;
          end
`endif
        end
        default: begin
          // Error entry: no memory beat to wait for, only a free response slot.
          if (rsp_free) begin
            pop          = 1'b1;
            rsp_load     = 1'b1;
            rsp_load_err = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // Storage array has no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else if (rsp_load) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= rsp_load_data;
      rsp_err_reg   <= rsp_load_err;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_byte_mask_mem_initiator.sv
// -----------------------------------------------------------------------------
// Testbench for byte_mask_mem_initiator: a byte-strobed SRAM model with
// one-cycle response latency, a table of single requests, hand-written
// multi-cycle sequences (back-to-back, back-pressure, reset), and a response
// scoreboard fed at request acceptance.
// -----------------------------------------------------------------------------
module tb_byte_mask_mem_initiator;

  localparam int DATAW       = 32;
  localparam int ADDRW       = 7;
  localparam int OUTSTANDING = 2;
`ifdef BMI_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [ADDRW+1:0] req_baddr;
  logic [DATAW-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DATAW-1:0] rsp_data;
  logic             rsp_err;
  logic             avalid;
  logic             aready;
  logic             awren;
  logic [3:0]       astrb;
  logic [ADDRW-1:0] aaddr;
  logic [DATAW-1:0] adata;
  logic             rvalid;
  logic             rready;
  logic [DATAW-1:0] rdata;

  always #5 clk = ~clk;

  byte_mask_mem_initiator #(
    .DATAW(DATAW), .ADDRW(ADDRW), .OUTSTANDING(OUTSTANDING)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_baddr(req_baddr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .avalid(avalid), .aready(aready), .awren(awren), .astrb(astrb),
    .aaddr(aaddr), .adata(adata),
    .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // SRAM model: samples at negedge, updates 1 time unit after posedge.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [128];
  logic [31:0] beat_q [$];
  bit          mem_hold;
  bit          flush_beats;
  int          acc_cnt = 0;

  initial begin : mem_model
    bit          acc, we_s, popb;
    logic [3:0]  st;
    logic [6:0]  ad;
    logic [31:0] wd, tmp;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    rvalid = 1'b0;
    rdata  = 32'h0;
    forever begin
      @(negedge clk);
      acc  = avalid && aready;
      we_s = awren; st = astrb; ad = aaddr; wd = adata;
      popb = rvalid && rready;
      @(posedge clk);
      #1;
      if (popb && beat_q.size() > 0) tmp = beat_q.pop_front();
      if (flush_beats) beat_q.delete();
      if (acc) begin
        acc_cnt++;
        if (we_s) begin
          for (int b = 0; b < 4; b++) if (st[b]) mem[ad][8*b +: 8] = wd[8*b +: 8];
          beat_q.push_back(32'h0);
        end else begin
          beat_q.push_back(mem[ad]);
        end
      end
      rvalid = !mem_hold && (beat_q.size() > 0);
      rdata  = rvalid ? beat_q[0] : 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;
  rsp_t exp_q [$];

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {31'h0, rsp_err, rsp_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {31'h0, rsp_err, rsp_data}, {31'h0, e.err, e.data});
          $display("rsp data=%08h err=%0b (exp %08h/%0b)", rsp_data, rsp_err, e.data, e.err);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string       nm;
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [8:0]  baddr;
    logic [31:0] wdata;
    bit          exp_avalid;
    logic [3:0]  exp_strb;
    logic [6:0]  exp_aaddr;
    logic [31:0] exp_adata;
    bit          exp_rsp;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(string nm, bit we, logic [1:0] size, bit sgn,
                              logic [8:0] baddr, logic [31:0] wdata,
                              bit eav, logic [3:0] estrb, logic [6:0] eaa,
                              logic [31:0] ead, bit ersp, logic [31:0] edata,
                              bit eerr);
    vec_t v;
    v.nm = nm; v.we = we; v.size = size; v.sgn = sgn; v.baddr = baddr;
    v.wdata = wdata; v.exp_avalid = eav; v.exp_strb = estrb;
    v.exp_aaddr = eaa; v.exp_adata = ead; v.exp_rsp = ersp;
    v.exp_data = edata; v.exp_err = eerr;
    return v;
  endfunction

  // Drive one request until accepted (bounded). Optionally check the
  // combinational request outputs in the first cycle.
  task automatic drive_req(input vec_t v, input bit chk);
    bit   accepted;
    rsp_t e;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_baddr  = v.baddr;
    req_wdata  = v.wdata;
    accepted   = 1'b0;
    for (int c = 0; c < 40 && !accepted; c++) begin
      @(negedge clk);
      if (chk && c == 0) begin
        check({v.nm, "_ctl"}, {61'h0, avalid, req_ready, awren}, {61'h0, v.exp_avalid, 1'b1, v.we});
        if (v.exp_avalid)
          check({v.nm, "_mem"}, {21'h0, astrb, aaddr, adata}, {21'h0, v.exp_strb, v.exp_aaddr, v.exp_adata});
        $display("req %s av=%0b rdy=%0b strb=%h aaddr=%0d adata=%08h", v.nm, avalid, req_ready, astrb, aaddr, adata);
      end
      if (req_ready) begin
        accepted = 1'b1;
        if (v.exp_rsp) begin
          e.data = v.exp_data;
          e.err  = v.exp_err;
          exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!accepted) check({v.nm, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  vec_t vt [18];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   acc0;
    bit   seen;
    vec_t v;

    vt[0]  = mk("wstore_08",  1, 2'd2, 0, 9'h008, 32'hDEADBEEF, 1, 4'hF, 7'd2,   32'hDEADBEEF, WACK, 32'h0, 0);
    vt[1]  = mk("bstore_0d",  1, 2'd0, 0, 9'h00D, 32'h123456A5, 1, 4'h2, 7'd3,   32'hA5A5A5A5, WACK, 32'h0, 0);
    vt[2]  = mk("hstore_0e",  1, 2'd1, 0, 9'h00E, 32'hCAFEBEEF, 1, 4'hC, 7'd3,   32'hBEEFBEEF, WACK, 32'h0, 0);
    vt[3]  = mk("wstore_0c",  1, 2'd2, 0, 9'h00C, 32'h1234A578, 1, 4'hF, 7'd3,   32'h1234A578, WACK, 32'h0, 0);
    vt[4]  = mk("sbread_0d",  0, 2'd0, 1, 9'h00D, 32'h0,        1, 4'h2, 7'd3,   32'h0, 1, 32'hFFFFFFA5, 0);
    vt[5]  = mk("ubread_0d",  0, 2'd0, 0, 9'h00D, 32'h0,        1, 4'h2, 7'd3,   32'h0, 1, 32'h000000A5, 0);
    vt[6]  = mk("shread_0e",  0, 2'd1, 1, 9'h00E, 32'h0,        1, 4'hC, 7'd3,   32'h0, 1, 32'h00001234, 0);
    vt[7]  = mk("shread_0c",  0, 2'd1, 1, 9'h00C, 32'h0,        1, 4'h3, 7'd3,   32'h0, 1, 32'hFFFFA578, 0);
    vt[8]  = mk("uhread_0c",  0, 2'd1, 0, 9'h00C, 32'h0,        1, 4'h3, 7'd3,   32'h0, 1, 32'h0000A578, 0);
    vt[9]  = mk("ubread_0f",  0, 2'd0, 0, 9'h00F, 32'h0,        1, 4'h8, 7'd3,   32'h0, 1, 32'h00000012, 0);
    vt[10] = mk("sbread_08",  0, 2'd0, 1, 9'h008, 32'h0,        1, 4'h1, 7'd2,   32'h0, 1, 32'hFFFFFFEF, 0);
    vt[11] = mk("wread_08",   0, 2'd2, 0, 9'h008, 32'h0,        1, 4'hF, 7'd2,   32'h0, 1, 32'hDEADBEEF, 0);
    vt[12] = mk("mis_hread",  0, 2'd1, 1, 9'h005, 32'h0,        0, 4'h0, 7'd1,   32'h0, 1, 32'h0, 1);
    vt[13] = mk("mis_wstore", 1, 2'd2, 0, 9'h00A, 32'h55AA55AA, 0, 4'h0, 7'd2,   32'h0, 1, 32'h0, 1);
    vt[14] = mk("size3_read", 0, 2'd3, 0, 9'h000, 32'h0,        0, 4'h0, 7'd0,   32'h0, 1, 32'h0, 1);
    vt[15] = mk("wstore_top", 1, 2'd2, 0, 9'h1FC, 32'h80000001, 1, 4'hF, 7'd127, 32'h80000001, WACK, 32'h0, 0);
    vt[16] = mk("sbread_top", 0, 2'd0, 1, 9'h1FF, 32'h0,        1, 4'h8, 7'd127, 32'h0, 1, 32'hFFFFFF80, 0);
    vt[17] = mk("mis_hread3", 0, 2'd1, 0, 9'h00F, 32'h0,        0, 4'h0, 7'd3,   32'h0, 1, 32'h0, 1);

    // Reset with an aligned request pending: outputs must be gated.
    rst = 1'b1; mem_hold = 1'b0; flush_beats = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_baddr = 9'h000; req_wdata = 32'h0; rsp_ready = 1'b1; aready = 1'b1;
    idle(2);
    @(negedge clk);
    check("reset_state", {26'h0, avalid, req_ready, rready, rsp_valid, rsp_err, rsp_data},
          {26'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    idle(2);

    // aready low: aligned request is offered but not accepted.
    aready = 1'b0; req_valid = 1'b1; req_size = 2'd2; req_baddr = 9'h00C;
    @(negedge clk);
    check("aready_low", {62'h0, avalid, req_ready}, {62'h0, 1'b1, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0; aready = 1'b1;
    idle(1);

    // Table-driven single requests.
    for (int i = 0; i < 18; i++) begin
      drive_req(vt[i], 1'b1);
      idle(4);
    end

    // Back-to-back aligned read then misaligned read: one memory access only.
    acc0 = acc_cnt;
    drive_req(mk("b2b_read", 0, 2'd2, 0, 9'h00C, 32'h0, 1, 4'hF, 7'd3, 32'h0, 1, 32'h1234A578, 0), 1'b0);
    drive_req(mk("b2b_mis",  0, 2'd1, 1, 9'h005, 32'h0, 0, 4'h0, 7'd1, 32'h0, 1, 32'h0, 1), 1'b0);
    idle(5);
    check("b2b_mem_accesses", 64'(acc_cnt - acc0), 64'd1);

    // Back-pressure: fill FIFO with memory held, then stall upstream.
    rsp_ready = 1'b0; mem_hold = 1'b1;
    idle(2);
    drive_req(mk("bp_read0", 0, 2'd2, 0, 9'h00C, 32'h0, 1, 4'hF, 7'd3, 32'h0, 1, 32'h1234A578, 0), 1'b0);
    drive_req(mk("bp_read1", 0, 2'd2, 0, 9'h008, 32'h0, 1, 4'hF, 7'd2, 32'h0, 1, 32'hDEADBEEF, 0), 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_baddr = 9'h00C;
    @(negedge clk);
    check("full_req_ready", {62'h0, avalid, req_ready}, {62'h0, 1'b0, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_hold  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("bp_first_rsp", {63'h0, seen}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_stall_hold", {31'h0, rready, rsp_data}, {31'h0, 1'b0, 32'h1234A578});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    idle(6);

    // Reset with two reads outstanding; stale beats must be refused.
    mem_hold = 1'b1;
    idle(2);
    drive_req(mk("rst_read0", 0, 2'd2, 0, 9'h00C, 32'h0, 1, 4'hF, 7'd3, 32'h0, 1, 32'h1234A578, 0), 1'b0);
    drive_req(mk("rst_read1", 0, 2'd2, 0, 9'h008, 32'h0, 1, 4'hF, 7'd2, 32'h0, 1, 32'hDEADBEEF, 0), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst", {30'h0, rsp_valid, req_ready, rsp_data}, {30'h0, 1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;
    mem_hold = 1'b0;
    idle(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stale_beat", {62'h0, rready, rsp_valid}, 64'd0);
    end
    @(posedge clk); #1;
    flush_beats = 1'b1;
    idle(2);
    flush_beats = 1'b0;
    idle(1);
    drive_req(mk("rst_newread", 0, 2'd0, 1, 9'h00D, 32'h0, 1, 4'h2, 7'd3, 32'h0, 1, 32'hFFFFFFA5, 0), 1'b0);
    idle(6);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
